// File: rtl/dispatcher_if.sv
// Bus bundle between the dispatcher and its neighbours: decoder offer,
// register-file / ROB operand lookup, back-pressure, CDB and issue payload.
// The slave modport is the dispatcher's view; master is the environment's.
interface dispatcher_if #(
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32
);
    // decoder handshake
    logic              dec_valid;
    logic              dec_ready;
    logic [OP_W-1:0]   dec_op_enum;
    logic [4:0]        dec_rs1;
    logic [4:0]        dec_rs2;
    logic [4:0]        dec_rd;
    logic              dec_has_rd;
    logic              dec_is_ls;
    logic [DATA_W-1:0] dec_imm;
    logic [DATA_W-1:0] dec_pc;

    // register file lookup
    logic [4:0]        rs1_to_reg;
    logic [4:0]        rs2_to_reg;
    logic [DATA_W-1:0] reg_V1;
    logic [DATA_W-1:0] reg_V2;
    logic [ROB_W-1:0]  reg_Q1;
    logic [ROB_W-1:0]  reg_Q2;

    // ROB lookup and allocation
    logic              rob_q1_ready;
    logic              rob_q2_ready;
    logic [DATA_W-1:0] rob_q1_value;
    logic [DATA_W-1:0] rob_q2_value;
    logic [ROB_W-1:0]  rob_free_id;

    // back-pressure
    logic              rob_full;
    logic              rs_full;
    logic              lsb_full;

    // common data bus
    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_rob_id;
    logic [DATA_W-1:0] cdb_value;

    // issue outputs
    logic              enable_to_rs;
    logic              enable_to_lsb;
    logic              enable_to_rob;
    logic              enable_to_reg;
    logic [DATA_W-1:0] V1_out;
    logic [DATA_W-1:0] V2_out;
    logic [DATA_W-1:0] imm_out;
    logic [DATA_W-1:0] inst_pos_out;
    logic [ROB_W-1:0]  Q1_out;
    logic [ROB_W-1:0]  Q2_out;
    logic [ROB_W-1:0]  rob_id_out;
    logic [OP_W-1:0]   op_enum_out;
    logic [4:0]        rd_out;

    modport slave (
        input  dec_valid, dec_op_enum, dec_rs1, dec_rs2, dec_rd, dec_has_rd,
               dec_is_ls, dec_imm, dec_pc,
               reg_V1, reg_V2, reg_Q1, reg_Q2,
               rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value, rob_free_id,
               rob_full, rs_full, lsb_full,
               cdb_valid, cdb_rob_id, cdb_value,
        output dec_ready, rs1_to_reg, rs2_to_reg,
               enable_to_rs, enable_to_lsb, enable_to_rob, enable_to_reg,
               V1_out, V2_out, imm_out, inst_pos_out,
               Q1_out, Q2_out, rob_id_out, op_enum_out, rd_out
    );

    modport master (
        output dec_valid, dec_op_enum, dec_rs1, dec_rs2, dec_rd, dec_has_rd,
               dec_is_ls, dec_imm, dec_pc,
               reg_V1, reg_V2, reg_Q1, reg_Q2,
               rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value, rob_free_id,
               rob_full, rs_full, lsb_full,
               cdb_valid, cdb_rob_id, cdb_value,
        input  dec_ready, rs1_to_reg, rs2_to_reg,
               enable_to_rs, enable_to_lsb, enable_to_rob, enable_to_reg,
               V1_out, V2_out, imm_out, inst_pos_out,
               Q1_out, Q2_out, rob_id_out, op_enum_out, rd_out
    );
endinterface

// File: rtl/dispatcher.sv
// Single-entry issue stage. Holds one decoded instruction, resolves its
// operands (register file, ROB, CDB, same-edge rename bypass), keeps them
// fresh by snooping the CDB, and issues a one-cycle registered pulse to the
// RS or LSB plus the ROB (and the register file when rd is renamed).
module dispatcher #(
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear_in,
    dispatcher_if.slave  bus
);

    typedef enum logic {
        S_EMPTY,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] v;
        logic [ROB_W-1:0]  q;
    } operand_t;

    state_t state, state_nxt;
    logic   buf_valid;
    logic   fire;
    logic   dec_ready;
    logic   accept;
    logic   rename_hit;

    // buffered instruction
    logic [OP_W-1:0]   buf_op;
    logic [4:0]        buf_rd;
    logic              buf_has_rd;
    logic              buf_is_ls;
    logic [DATA_W-1:0] buf_imm;
    logic [DATA_W-1:0] buf_pc;
    operand_t          buf_op1, buf_op2;

    // operands after this cycle's CDB snoop, and operands of the incoming instruction
    operand_t snp_op1, snp_op2;
    operand_t res_op1, res_op2;

    // issue output registers
    logic              en_rs_q, en_lsb_q, en_rob_q, en_reg_q;
    logic [DATA_W-1:0] v1_q, v2_q, imm_q, pc_q;
    logic [ROB_W-1:0]  q1_q, q2_q, rob_id_q;
    logic [OP_W-1:0]   op_q;
    logic [4:0]        rd_q;

    // Resolve one source of the incoming instruction; earlier rules win.
    function automatic operand_t resolve_operand(
        input logic [4:0]        rs,
        input logic [DATA_W-1:0] reg_v,
        input logic [ROB_W-1:0]  reg_q,
        input logic              rob_rdy,
        input logic [DATA_W-1:0] rob_val,
        input logic              ren_hit,
        input logic [4:0]        ren_rd,
        input logic [ROB_W-1:0]  ren_tag,
        input logic              cdb_v,
        input logic [ROB_W-1:0]  cdb_id,
        input logic [DATA_W-1:0] cdb_val
    );
        operand_t r;
        r = '0;
        if (rs == 5'd0) begin
            r = '0;                          // x0 always reads zero
        end else if (ren_hit && ren_rd == rs) begin
            r.q = ren_tag;                   // producer issues on this very edge
        end else if (reg_q == '0) begin
            r.v = reg_v;
        end else if (rob_rdy) begin
            r.v = rob_val;
        end else if (cdb_v && cdb_id == reg_q) begin
            r.v = cdb_val;
        end else begin
            r.q = reg_q;
        end
        return r;
    endfunction

    // Capture a broadcast result for a pending (nonzero) tag.
    function automatic operand_t snoop_operand(
        input operand_t          op,
        input logic              cdb_v,
        input logic [ROB_W-1:0]  cdb_id,
        input logic [DATA_W-1:0] cdb_val
    );
        operand_t r;
        r = op;
        if (cdb_v && op.q != '0 && cdb_id == op.q) begin
            r.v = cdb_val;
            r.q = '0;
        end
        return r;
    endfunction

    assign buf_valid = (state == S_HOLD);

    // State register: only advances while the global enable is high.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= S_EMPTY;
        end else if (rdy_in) begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // flop samples the pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    // Next-state: flush beats accept, accept beats a plain issue.
    always_comb begin
        state_nxt = state;
        if (clear_in) begin
            state_nxt = S_EMPTY;
        end else if (accept) begin
            state_nxt = S_HOLD;
        end else if (fire) begin
            state_nxt = S_EMPTY;
        end
    end

    // Handshake outputs: issue when the target queue and ROB have room.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path to avoid latches.
        fire       = 1'b0;
        dec_ready  = 1'b0;
        accept     = 1'b0;
        rename_hit = 1'b0;
        if (buf_valid) begin
            fire = !bus.rob_full && (buf_is_ls ? !bus.lsb_full : !bus.rs_full);
        end
        dec_ready  = !buf_valid || fire;
        accept     = bus.dec_valid && dec_ready && rdy_in && !clear_in;
        rename_hit = fire && buf_has_rd && (buf_rd != 5'd0);
    end

    // Operand resolution for the incoming instruction and CDB snoop of the held one.
    always_comb begin
        res_op1 = resolve_operand(bus.dec_rs1, bus.reg_V1, bus.reg_Q1,
                                  bus.rob_q1_ready, bus.rob_q1_value,
                                  rename_hit, buf_rd, bus.rob_free_id,
                                  bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
        res_op2 = resolve_operand(bus.dec_rs2, bus.reg_V2, bus.reg_Q2,
                                  bus.rob_q2_ready, bus.rob_q2_value,
                                  rename_hit, buf_rd, bus.rob_free_id,
                                  bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
        snp_op1 = snoop_operand(buf_op1, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
        snp_op2 = snoop_operand(buf_op2, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
    end

    // Instruction buffer: load on accept, otherwise keep snooping while held.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            // NOTE: the buffer payload is reset as well so nothing X ever reaches
            // the output registers; validity alone lives in the state register.
            buf_op     <= '0;
            buf_rd     <= '0;
            buf_has_rd <= 1'b0;
            buf_is_ls  <= 1'b0;
            buf_imm    <= '0;
            buf_pc     <= '0;
            buf_op1    <= '0;
            buf_op2    <= '0;
        end else if (rdy_in) begin
            if (accept) begin
                buf_op     <= bus.dec_op_enum;
                buf_rd     <= bus.dec_rd;
                buf_has_rd <= bus.dec_has_rd;
                buf_is_ls  <= bus.dec_is_ls;
                buf_imm    <= bus.dec_imm;
                buf_pc     <= bus.dec_pc;
                buf_op1    <= res_op1;
                buf_op2    <= res_op2;
            end else if (buf_valid) begin
                buf_op1 <= snp_op1;
                buf_op2 <= snp_op2;
            end
        end
    end

    // Issue registers: one-cycle enable pulses, payload held between issues.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            en_rs_q  <= 1'b0;
            en_lsb_q <= 1'b0;
            en_rob_q <= 1'b0;
            en_reg_q <= 1'b0;
            v1_q     <= '0;
            v2_q     <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            q1_q     <= '0;
            q2_q     <= '0;
            rob_id_q <= '0;
            op_q     <= '0;
            rd_q     <= '0;
        end else if (rdy_in) begin
            if (!clear_in && fire) begin
                en_rs_q  <= !buf_is_ls;
                en_lsb_q <= buf_is_ls;
                en_rob_q <= 1'b1;
                en_reg_q <= buf_has_rd && (buf_rd != 5'd0);
                v1_q     <= snp_op1.v;
                v2_q     <= snp_op2.v;
                q1_q     <= snp_op1.q;
                q2_q     <= snp_op2.q;
                imm_q    <= buf_imm;
                pc_q     <= buf_pc;
                rob_id_q <= bus.rob_free_id;
                op_q     <= buf_op;
                rd_q     <= buf_rd;
            end else begin
                en_rs_q  <= 1'b0;
                en_lsb_q <= 1'b0;
                en_rob_q <= 1'b0;
                en_reg_q <= 1'b0;
            end
        end
    end

    assign bus.dec_ready     = dec_ready;
    assign bus.rs1_to_reg    = bus.dec_rs1;
    assign bus.rs2_to_reg    = bus.dec_rs2;
    assign bus.enable_to_rs  = en_rs_q;
    assign bus.enable_to_lsb = en_lsb_q;
    assign bus.enable_to_rob = en_rob_q;
    assign bus.enable_to_reg = en_reg_q;
    assign bus.V1_out        = v1_q;
    assign bus.V2_out        = v2_q;
    assign bus.imm_out       = imm_q;
    assign bus.inst_pos_out  = pc_q;
    assign bus.Q1_out        = q1_q;
    assign bus.Q2_out        = q2_q;
    assign bus.rob_id_out    = rob_id_q;
    assign bus.op_enum_out   = op_q;
    assign bus.rd_out        = rd_q;

endmodule

// File: doc/dispatcher.md
Name: dispatcher

Overview:
- Single-entry issue stage between the instruction decoder and the back end (reservation station, load/store buffer, reorder buffer).
- Latches one decoded instruction and resolves its operands. Sources: register file, then ROB, then CDB bypass.
- Allocates a ROB id, renames rd in the register file, and emits a one-cycle registered issue pulse to RS or LSB plus ROB.
- While holding an instruction, it snoops the CDB so issued operands are never stale.

Parameters:
ROB_W, 4, width of ROB id; id 0 is reserved and means "no dependency"
OP_W, 6, width of op_enum
DATA_W, 32, data/address width

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; low freezes all state
clear_in  in  1  misprediction flush, synchronous
dec_valid  in  1  decoder offers instruction
dec_ready  out  1  dispatcher accepts this cycle (combinational)
dec_op_enum  in  OP_W  operation
dec_rs1, dec_rs2, dec_rd  in  5  register indices
dec_has_rd  in  1  instruction writes rd
dec_is_ls  in  1  route to LSB instead of RS
dec_imm, dec_pc  in  DATA_W  immediate, instruction address
rs1_to_reg, rs2_to_reg  out  5  = dec_rs1/dec_rs2 (combinational)
reg_V1, reg_V2  in  DATA_W  register values
reg_Q1, reg_Q2  in  ROB_W  register rename tags
rob_q1_ready, rob_q2_ready  in  1  ROB entry reg_Qx already has result
rob_q1_value, rob_q2_value  in  DATA_W  that result
rob_free_id  in  ROB_W  next ROB id to allocate
rob_full, rs_full, lsb_full  in  1  back-pressure
cdb_valid  in  1  broadcast valid
cdb_rob_id  in  ROB_W  broadcast tag
cdb_value  in  DATA_W  broadcast value
enable_to_rs, enable_to_lsb, enable_to_rob, enable_to_reg  out  1  registered issue pulses
V1_out, V2_out, imm_out, inst_pos_out  out  DATA_W  issued payload
Q1_out, Q2_out, rob_id_out  out  ROB_W  issued tags
op_enum_out  out  OP_W  issued op
rd_out  out  5  rd to rename in the register file

Behaviour:
- Reset (rst_in=0, async):
  - Buffer invalid.
  - All outputs 0: every enable_* = 0, all payload and tag outputs = 0.
- rdy_in=0: no register changes, including the output registers.
- dec_ready = !buf_valid || fire.
- fire = buf_valid && !rob_full && (buf_is_ls ? !lsb_full : !rs_full).
- Accept on dec_valid && dec_ready; the buffer loads at that edge.
- Operand resolution at accept, per operand, first match wins:
  1. rs==0 → V=0, Q=0.
  2. fire && buf_has_rd && buf_rd!=0 && buf_rd==rs → Q=rob_free_id. This is the same-edge rename bypass.
  3. reg_Q==0 → V=reg_V.
  4. rob_qx_ready → V=rob_qx_value, Q=0.
  5. cdb_valid && cdb_rob_id==reg_Q → V=cdb_value, Q=0.
  6. Otherwise Q=reg_Q.
- While buf_valid, each cycle: if cdb_valid and cdb_rob_id equals a nonzero buffered Qx, then Vx←cdb_value and Qx←0. This also applies on the issuing edge, so issued Q1_out/Q2_out already reflect that cycle's CDB.
- On fire edge:
  - Output registers load the buffer contents.
  - rob_id_out←rob_free_id.
  - enable_to_rob←1.
  - enable_to_rs←!buf_is_ls; enable_to_lsb←buf_is_ls.
  - enable_to_reg←buf_has_rd && buf_rd!=0.
  - The buffer clears unless a new instruction is accepted on the same edge.
- All enables are high for exactly one cycle per fire.
- Latency: accepted at edge E, earliest pulse at edge E+1. Sustained throughput is 1 instruction/cycle when nothing is full.
- Full: instruction held indefinitely; dec_ready=0; CDB snooping continues.
- clear_in=1 (with rdy_in): at the edge, buffer invalid, all enables←0, no accept, no fire. clear_in has priority over fire and accept.
- rd==0: never sent to the register file; ROB entry still allocated.

Test Plan:
- Reset mid-hold: rst_in low while buf_valid → all enables 0 immediately; dec_ready=1 after release.
- Back-to-back ADDI x1 then ADD x2,x1,x1 with reg tags 0, rob_free_id=3 → second issues with Q1=Q2=3 one cycle after the first issue.
- Held with rs_full=1, buffered Q1=5; cdb_valid, id 5, value 0x1234 → after rs_full drops: V1_out=0x1234, Q1_out=0, enable_to_rs pulse width 1.
- Load with lsb_full=0, rs_full=1 → enable_to_lsb=1, enable_to_rs=0, enable_to_rob=1.
- reg_Q1=7, rob_q1_ready=1, rob_q1_value=0xDEAD → V1_out=0xDEAD, Q1_out=0.
- clear_in on the same cycle fire would occur → no enable pulse next cycle; buffer empty; rs1=x0 gives V1=0, Q1=0.
